// File: rtl/trigger_uart_pattern.sv
// trigger_uart_pattern
// 8N1 UART receiver with a masked multi-byte pattern matcher. trigger_o
// pulses once for every received byte that completes a match against the
// most recent pat_len bytes. A stop bit sampled low is treated as a frame
// error or break: the byte is dropped and the match history is cleared.
module trigger_uart_pattern #(
  parameter int MAX_BYTES = 8,
  parameter int DIV_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic [8*MAX_BYTES-1:0] pattern,
  input  logic [8*MAX_BYTES-1:0] mask,
  input  logic [4:0]             pat_len,
  input  logic                   rx_i,
  output logic [7:0]             byte_o,
  output logic                   byte_valid_o,
  output logic                   frame_err_o,
  output logic                   trigger_o
);

  localparam int         HIST_W  = 8 * MAX_BYTES;
  localparam logic [4:0] MAX_LEN = 5'(MAX_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  // A history byte matches when every bit selected by the mask agrees
  function automatic logic byte_hit(input logic [7:0] h, input logic [7:0] p,
                                    input logic [7:0] m);
    return ((h ^ p) & m) == 8'h00;
  endfunction

  logic              rx_meta_r;
  logic              rxs_r;
  rx_state_t         state_r,   state_nxt_s;
  logic [DIV_W-1:0]  cnt_r,     cnt_nxt_s;
  logic [2:0]        bit_idx_r, bit_idx_nxt_s;
  logic [7:0]        shift_r,   shift_nxt_s;
  logic [HIST_W-1:0] hist_r,    hist_nxt_s;
  logic [4:0]        count_r,   count_nxt_s;
  logic [7:0]        byte_nxt_s;
  logic              valid_nxt_s;
  logic              ferr_nxt_s;
  logic              trig_nxt_s;

  logic [DIV_W-1:0]  baud_eff_s;
  logic [DIV_W-1:0]  bit_load_s;
  logic [DIV_W-1:0]  half_load_s;
  logic              cnt_zero_s;
  logic [4:0]        len_s;
  logic              match_s;

  // Divider below 2 would leave no room for a half-bit start delay
  assign baud_eff_s  = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign bit_load_s  = baud_eff_s - DIV_W'(1);
  assign half_load_s = (baud_eff_s >> 1) - DIV_W'(1);
  assign cnt_zero_s  = (cnt_r == DIV_W'(0));
  assign len_s       = (pat_len > MAX_LEN) ? MAX_LEN : pat_len;

  // Two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rxs_r     <= rx_meta_r;
    end
  end

  // Compare the freshly updated history against the masked pattern
  always_comb begin
    match_s = (len_s != 5'd0) && (count_r >= len_s);
    for (int i = 0; i < MAX_BYTES; i++) begin
      match_s = match_s & ((5'(i) >= len_s) |
                           byte_hit(hist_r[8*i +: 8], pattern[8*i +: 8], mask[8*i +: 8]));
    end
  end

  // Receiver next-state, history update and output pulse generation
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_zero_s ? cnt_r : (cnt_r - DIV_W'(1));
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    hist_nxt_s    = hist_r;
    count_nxt_s   = count_r;
    byte_nxt_s    = byte_o;
    valid_nxt_s   = 1'b0;
    ferr_nxt_s    = 1'b0;
    trig_nxt_s    = 1'b0;

    if (!enable) begin
      // Disabled: drop any frame in flight, forget history, quiet outputs
      state_nxt_s = ST_IDLE;
      hist_nxt_s  = {HIST_W{1'b0}};
      count_nxt_s = 5'd0;
      byte_nxt_s  = 8'h00;
    end else begin
      // History was updated on the edge that raised byte_valid_o
      trig_nxt_s = byte_valid_o & match_s;
      case (state_r)
        ST_IDLE: begin
          if (!rxs_r) begin
            state_nxt_s = ST_START;
            cnt_nxt_s   = half_load_s;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_zero_s && rxs_r) begin
            state_nxt_s = ST_IDLE;           // glitch shorter than half a bit
          end else if (cnt_zero_s) begin
            state_nxt_s   = ST_DATA;
            cnt_nxt_s     = bit_load_s;
            bit_idx_nxt_s = 3'd0;
          end else begin
            state_nxt_s = ST_START;
          end
        end
        ST_DATA: begin
          if (cnt_zero_s) begin
            shift_nxt_s   = {rxs_r, shift_r[7:1]};   // LSB arrives first
            cnt_nxt_s     = bit_load_s;
            bit_idx_nxt_s = bit_idx_r + 3'd1;
            state_nxt_s   = (bit_idx_r == 3'd7) ? ST_STOP : ST_DATA;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_STOP: begin
          if (cnt_zero_s && rxs_r) begin
            state_nxt_s = ST_IDLE;
            byte_nxt_s  = shift_r;
            valid_nxt_s = 1'b1;
            hist_nxt_s  = hist_r << 4'd8;
            hist_nxt_s[7:0] = shift_r;
            count_nxt_s = (count_r < MAX_LEN) ? (count_r + 5'd1) : count_r;
          end else if (cnt_zero_s) begin
            state_nxt_s = ST_BREAK;
            ferr_nxt_s  = 1'b1;
            hist_nxt_s  = {HIST_W{1'b0}};
            count_nxt_s = 5'd0;
          end else begin
            state_nxt_s = ST_STOP;
          end
        end
        ST_BREAK: begin
          if (rxs_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BREAK;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= DIV_W'(0);
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      hist_r       <= {HIST_W{1'b0}};
      count_r      <= 5'd0;
      byte_o       <= 8'h00;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      trigger_o    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      bit_idx_r    <= bit_idx_nxt_s;
      shift_r      <= shift_nxt_s;
      hist_r       <= hist_nxt_s;
      count_r      <= count_nxt_s;
      byte_o       <= byte_nxt_s;
      byte_valid_o <= valid_nxt_s;
      frame_err_o  <= ferr_nxt_s;
      trigger_o    <= trig_nxt_s;
    end
  end

endmodule
